// File: rtl/barret_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : barret_pkg
//  Description : Shared constants, the clog2 helper and the pipeline stage
//                records for the shared mod-2969 reduction scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package barret_pkg;

    // Modulus and the operand/result widths of the reducer.
    localparam int Q        = 2969;
    localparam int DIN_W    = 23;
    localparam int DOUT_W   = 12;

    // The id field is sized for the largest supported requester count (8).
    localparam int MAX_ID_W = 3;

    // Ceiling log2, with a minimum result of 1 so that index ports never
    // collapse to zero width.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << r) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // S1 record: the operand waiting at the reducer input, plus its origin.
    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic [DIN_W-1:0]    data;
    } s1_rec_t;

    // S2 record: the reduced value presented on the result port.
    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic [DOUT_W-1:0]   data;
    } s2_rec_t;

endpackage
`default_nettype wire

// File: rtl/barret_for_2969.sv
`default_nettype none
// ============================================================================
//  Module      : barret_for_2969
//  Description : Combinational Barrett reduction, dout_r = din_a mod 2969.
//  Ports       : din_a  [22:0] operand (any 23-bit value)
//                dout_r [11:0] operand mod 2969
//  Revision    : 1.0 - initial release
// ============================================================================
module barret_for_2969 (
    input  logic [22:0] din_a,
    output logic [11:0] dout_r
);

    // m = floor(2^24 / 2969). For x < 2^23 the quotient estimate is low by at
    // most one, so the remainder is below 2q and a single conditional
    // subtraction finishes the reduction.
    localparam int c_q = 2969;
    localparam int c_m = 5650;

    logic [35:0] w_prod;
    logic [11:0] w_qe;
    logic [23:0] w_qq;
    logic [23:0] w_diff;
    logic [12:0] w_r;

    assign w_prod = 36'(din_a) * 36'(c_m);
    assign w_qe   = 12'(w_prod >> 24);
    assign w_qq   = 24'(w_qe) * 24'(c_q);
    assign w_diff = {1'b0, din_a} - w_qq;
    assign w_r    = 13'(w_diff);
    assign dout_r = (w_r >= 13'(c_q)) ? 12'(w_r - 13'(c_q)) : 12'(w_r);

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Picks the first set
//                request scanning upward from the pointer with wrap-around.
//  Ports       : req     [N_REQ-1:0] request vector
//                pointer [ID_W-1:0]  highest-priority index
//                enable              gates the grant strobe
//                grant   [N_REQ-1:0] one-hot grant (zero if none / disabled)
//                index   [ID_W-1:0]  encoded winner (valid when found)
//                found               at least one request is set
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import barret_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  pointer,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  index,
    output logic             found
);

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_slot;

    always_comb begin
        grant  = '0;
        index  = '0;
        found  = 1'b0;
        w_sum  = '0;
        w_slot = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // Slot = (pointer + k) mod N_REQ, without a divider.
            w_sum = {1'b0, pointer} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(N_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(N_REQ);
            end
            w_slot = w_sum[ID_W-1:0];
            if (!found && req[w_slot]) begin
                found = 1'b1;
                index = w_slot;
            end
        end
        grant[index] = found & enable;
    end

endmodule
`default_nettype wire

// File: rtl/barret_2969_sched.sv
`default_nettype none
// ============================================================================
//  Module      : barret_2969_sched
//  Description : Round-robin scheduler sharing one mod-2969 reducer among
//                N_REQ requesters. Two-stage pipeline (operand register,
//                result register) with a valid/ready result port.
//  Ports       : clk, rst_n                 clock, sync active-low reset
//                req_valid [N_REQ-1:0]       per-requester operand valid
//                req_data  [N_REQ*DIN_W-1:0] packed operands
//                req_ready [N_REQ-1:0]       one-hot accept strobe
//                res_valid/res_data/res_id   tagged result
//                res_ready                   downstream accept
//                ops_count [CNT_W-1:0]       saturating delivered count
//  Revision    : 1.0 - initial release
// ============================================================================
module barret_2969_sched
    import barret_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2,
    parameter int DIN_W  = 23,
    parameter int DOUT_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*DIN_W-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   res_valid,
    output logic [DOUT_W-1:0]      res_data,
    output logic [ID_W-1:0]        res_id,
    input  logic                   res_ready,
    output logic [CNT_W-1:0]       ops_count
);

    logic             r_s1_valid;
    s1_rec_t          r_s1;
    logic             r_s2_valid;
    s2_rec_t          r_s2;
    logic [ID_W-1:0]  r_ptr;
    logic [CNT_W-1:0] r_ops;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_s1_free;
    logic [N_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_idx;
    logic             w_found;
    logic             w_accept;
    logic [ID_W-1:0]  w_ptr_next;
    logic [11:0]      w_red;
    logic [DIN_W-1:0] w_operand [N_REQ];

    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
            assign w_operand[g] = req_data[g*DIN_W +: DIN_W];
        end
    endgenerate

    assign w_s2_adv  = !r_s2_valid || res_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_adv;
    assign w_s1_free = !r_s1_valid || w_s2_adv;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req     (req_valid),
        .pointer (r_ptr),
        .enable  (w_s1_free),
        .grant   (w_grant),
        .index   (w_idx),
        .found   (w_found)
    );

    // Ready is forced low while reset is held so nothing looks accepted.
    assign req_ready  = rst_n ? w_grant : '0;
    assign w_accept   = rst_n && w_found && w_s1_free;
    assign w_ptr_next = (w_idx == ID_W'(N_REQ-1)) ? '0 : w_idx + ID_W'(1);

    barret_for_2969 u_red (
        .din_a  (r_s1.data),
        .dout_r (w_red)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
            r_s2_valid <= 1'b0;
            r_s2       <= '0;
            r_ptr      <= '0;
            r_ops      <= '0;
        end else begin
            // A new accept overrides the clear, keeping S1 full for
            // back-to-back operation.
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1.id    <= MAX_ID_W'(w_idx);
                r_s1.data  <= w_operand[w_idx];
                r_ptr      <= w_ptr_next;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end

            // Payload only moves with a valid operand so an idle result
            // port keeps its last value.
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2.data <= w_red;
                    r_s2.id   <= r_s1.id;
                end
            end

            if (r_s2_valid && res_ready && (r_ops != '1)) begin
                r_ops <= r_ops + CNT_W'(1);
            end
        end
    end

    assign res_valid = r_s2_valid;
    assign res_data  = DOUT_W'(r_s2.data);
    assign res_id    = ID_W'(r_s2.id);
    assign ops_count = r_ops;

endmodule
`default_nettype wire

// File: tb/tb_barret_2969_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_barret_2969_sched
//  Description : Directed self-checking bench for barret_2969_sched. A second
//                instance with a 4-bit counter shares all inputs to exercise
//                counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_barret_2969_sched;

    localparam int c_n   = 4;
    localparam int c_dw  = 23;

    logic              clk;
    logic              rst_n;
    logic [c_n-1:0]    req_valid;
    logic [c_n*c_dw-1:0] req_data;
    logic              res_ready;

    logic [c_n-1:0]    req_ready;
    logic              res_valid;
    logic [11:0]       res_data;
    logic [1:0]        res_id;
    logic [15:0]       ops_count;

    logic [c_n-1:0]    req_ready_s;
    logic              res_valid_s;
    logic [11:0]       res_data_s;
    logic [1:0]        res_id_s;
    logic [3:0]        ops_count_s;

    int n_assert = 0;
    int n_fail   = 0;

    barret_2969_sched #(
        .N_REQ(4), .ID_W(2), .DIN_W(23), .DOUT_W(12), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .res_valid(res_valid), .res_data(res_data),
        .res_id(res_id), .res_ready(res_ready), .ops_count(ops_count)
    );

    barret_2969_sched #(
        .N_REQ(4), .ID_W(2), .DIN_W(23), .DOUT_W(12), .CNT_W(4)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready_s), .res_valid(res_valid_s), .res_data(res_data_s),
        .res_id(res_id_s), .res_ready(res_ready), .ops_count(ops_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [22:0] bnd_in  [5];
    logic [11:0] bnd_out [5];
    logic [22:0] fair_in [4];
    logic [11:0] fair_out[4];

    initial begin
        bnd_in[0] = 23'd0;       bnd_out[0] = 12'd0;
        bnd_in[1] = 23'd2968;    bnd_out[1] = 12'd2968;
        bnd_in[2] = 23'd2969;    bnd_out[2] = 12'd0;
        bnd_in[3] = 23'd5937;    bnd_out[3] = 12'd2968;
        bnd_in[4] = 23'd8388607; bnd_out[4] = 12'd1182;
        fair_in[0] = 23'd100000;  fair_out[0] = 12'd2023;
        fair_in[1] = 23'd200000;  fair_out[1] = 12'd1077;
        fair_in[2] = 23'd3000;    fair_out[2] = 12'd31;
        fair_in[3] = 23'd8388607; fair_out[3] = 12'd1182;

        // ---------------- reset state ----------------
        rst_n = 1'b0; req_valid = '0; req_data = '0; res_ready = 1'b1;
        tick(); tick();
        req_valid = 4'hF;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data",  32'(res_data),  32'd0);
        chk("rst_res_id",    32'(res_id),    32'd0);
        chk("rst_ops_count", 32'(ops_count), 32'd0);
        req_valid = '0;
        rst_n = 1'b1;
        tick();

        // ---------------- single request on requester 2 ----------------
        req_valid = 4'b0100;
        req_data[2*c_dw +: c_dw] = 23'd12345;
        #1;
        chk("single_req_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        #1;
        chk("single_lat_t1", 32'(res_valid), 32'd0);
        tick();
        chk("single_valid", 32'(res_valid), 32'd1);
        chk("single_data",  32'(res_data),  32'd469);
        chk("single_id",    32'(res_id),    32'd2);
        tick();
        chk("single_drain", 32'(res_valid), 32'd0);
        chk("single_count", 32'(ops_count), 32'd1);

        // ---------------- boundary values on requester 0 ----------------
        for (int k = 0; k < 6; k++) begin
            if (k < 5) begin
                req_valid = 4'b0001;
                req_data[0 +: c_dw] = bnd_in[k];
                #1;
                chk("bnd_req_ready", 32'(req_ready), 32'b0001);
            end else begin
                req_valid = '0;
            end
            tick();
            if (k >= 1) begin
                chk("bnd_valid", 32'(res_valid), 32'd1);
                chk("bnd_data",  32'(res_data),  32'(bnd_out[k-1]));
                chk("bnd_id",    32'(res_id),    32'd0);
            end
        end
        tick();
        chk("bnd_count", 32'(ops_count), 32'd6);

        // ---------------- reset mid-stream ----------------
        for (int i = 0; i < c_n; i++) req_data[i*c_dw +: c_dw] = fair_in[i];
        req_valid = 4'hF;
        res_ready = 1'b0;
        tick();
        tick();
        chk("mid_full_valid", 32'(res_valid), 32'd1);
        chk("mid_full_ready", 32'(req_ready), 32'h0);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_count", 32'(ops_count), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        rst_n = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
        tick();
        chk("mid_stale_1", 32'(res_valid), 32'd0);
        tick();
        chk("mid_stale_2", 32'(res_valid), 32'd0);
        chk("mid_stale_cnt", 32'(ops_count), 32'd0);

        // ---------------- fairness: 8 accepts from 4 requesters ----------------
        req_valid = 4'hF;
        #1;
        chk("fair_ptr0", 32'(req_ready), 32'b0001);
        for (int k = 0; k < 9; k++) begin
            req_valid = (k < 8) ? 4'hF : 4'h0;
            tick();
            if (k >= 1) begin
                chk("fair_valid", 32'(res_valid), 32'd1);
                chk("fair_id",    32'(res_id),    32'((k-1) % 4));
                chk("fair_data",  32'(res_data),  32'(fair_out[(k-1) % 4]));
            end
        end
        tick();
        chk("fair_drain", 32'(res_valid), 32'd0);
        chk("fair_count", 32'(ops_count), 32'd8);

        // ---------------- backpressure ----------------
        req_valid = 4'hF;
        res_ready = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_id",    32'(res_id),    32'd0);
            chk("bp_data",  32'(res_data),  32'd2023);
            chk("bp_ready", 32'(req_ready), 32'h0);
        end
        req_valid = '0;
        res_ready = 1'b1;
        tick();
        chk("bp_next_valid", 32'(res_valid), 32'd1);
        chk("bp_next_id",    32'(res_id),    32'd1);
        chk("bp_next_data",  32'(res_data),  32'd1077);
        tick();
        chk("bp_empty", 32'(res_valid), 32'd0);
        chk("bp_count", 32'(ops_count), 32'd10);

        // ---------------- counter saturation (20 ops) ----------------
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_data[0 +: c_dw] = 23'd5;
        for (int k = 0; k < 22; k++) begin
            req_valid = (k < 20) ? 4'b0001 : 4'b0000;
            tick();
        end
        chk("sat_main_count", 32'(ops_count), 32'd20);
        chk("sat_count",      32'(ops_count_s), 32'd15);
        chk("sat_valid",      32'(res_valid_s), 32'd0);
        chk("sat_last_data",  32'(res_data_s),  32'd5);
        chk("sat_last_id",    32'(res_id_s),    32'd0);
        req_valid = 4'b0001;
        #1;
        chk("sat_req_ready",  32'(req_ready_s), 32'b0001);
        req_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
